parallel_in_parallel_out_pipo_8_bit: RTL and testbench
======================================================

PARALLEL_IN_PARALLEL_OUT_PIPO_8_BIT -- requirements
Module: parallel_in_parallel_out_pipo_8_bit

Interface
REQ-001 The block SHALL have one parameter, DATA_WIDTH, default 8, giving the register and data bus width; all requirements below use the default.
REQ-002 The block SHALL have port Clk_In, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset_In, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Enable_In, input, 1 bit: block enable; gates both loading and output drive.
REQ-005 The block SHALL have port Load_Data_Signal_In, input, 1 bit: parallel-load request.
REQ-006 The block SHALL have port Parallel_Data_In, input, 8 bits: parallel load data.
REQ-007 The block SHALL have port Parallel_Data_Out, output, 8 bits: tri-stateable parallel output.

Function
REQ-008 The block SHALL hold one 8-bit storage register named r_Shift_Register, visible by hierarchical reference for debug.
REQ-009 On a rising Clk_In edge with Reset_In high, Enable_In=1 and Load_Data_Signal_In=1, r_Shift_Register SHALL capture Parallel_Data_In, with 1-cycle latency from the input to the output.
REQ-010 On a rising edge with Enable_In=1 and Load_Data_Signal_In=0, r_Shift_Register SHALL hold its value.
REQ-011 On a rising edge with Enable_In=0, r_Shift_Register SHALL hold its value regardless of Load_Data_Signal_In and Parallel_Data_In.
REQ-012 While Enable_In=1, Parallel_Data_Out SHALL combinationally equal r_Shift_Register.
REQ-013 While Enable_In=0, Parallel_Data_Out SHALL be high-impedance (8'hZZ) on all bits, combinationally, with no clock dependence.
REQ-014 When Enable_In rises, Parallel_Data_Out SHALL show the held register value immediately, without waiting for a clock edge.
REQ-015 The block SHALL not shift; data moves only by full-width parallel load. Bits SHALL map one-to-one (bit i in to bit i out).
REQ-016 There SHALL be no handshake, no ready/valid signalling and no wrap or overflow condition.

Reset
REQ-017 Reset_In low SHALL asynchronously force r_Shift_Register to 8'h00, taking priority over Enable_In and Load_Data_Signal_In.
REQ-018 While Reset_In is low, Parallel_Data_Out SHALL still follow REQ-012 and REQ-013: 8'h00 if Enable_In=1, Z if Enable_In=0.
REQ-019 Reset release SHALL be synchronous-safe: the first load SHALL occur on the first rising edge at which Reset_In is high.
REQ-020 Asserting Reset_In between loads SHALL discard the stored value immediately.

Structure
REQ-021 A shared package SHALL define the DATA_WIDTH default constant (8) and the reset value constant (8'h00).
REQ-022 The block SHALL be a single module with one always_ff process for the register and one continuous tri-state assign for the output; no sub-module is required.

Verification
REQ-023 Reset: with Enable_In=1 and Reset_In=0 -> Parallel_Data_Out=8'h00 immediately; holds 8'h00 after release while Load_Data_Signal_In=0.
REQ-024 Load: with Reset_In=1, Enable_In=1, Load_Data_Signal_In=1, apply Parallel_Data_In 8'hA5 then 8'h3C on consecutive edges -> output is 8'hA5 then 8'h3C, each one cycle after its input.
REQ-025 Hold: after loading 8'h5A, set Load_Data_Signal_In=0 and Parallel_Data_In=8'hFF for 3 cycles -> output stays 8'h5A.
REQ-026 Tri-state: set Enable_In=0 with Load_Data_Signal_In=1 and Parallel_Data_In=8'h77 -> output is Z; re-enable with Load_Data_Signal_In=0 -> output returns to the prior value, not 8'h77.
REQ-027 Asynchronous reset mid-operation: holding 8'hC3, pull Reset_In low between clock edges -> output is 8'h00 before the next edge.
REQ-028 Random: 20 cycles of random Load_Data_Signal_In and Parallel_Data_In with Enable_In=1 -> output matches the reference model every cycle, checked with a 4-state (===) compare.

Source files
------------

// File: rtl/parallel_in_parallel_out_pipo_8_bit_pkg.sv
// Shared constants for the 8-bit parallel-in/parallel-out register.
package parallel_in_parallel_out_pipo_8_bit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam logic [DATA_WIDTH_DEF-1:0] RESET_VALUE = 8'h00;

endpackage : parallel_in_parallel_out_pipo_8_bit_pkg

// File: rtl/parallel_in_parallel_out_pipo_8_bit_if.sv
// Control/data bundle for the PIPO register: enable, load request and load data.
interface parallel_in_parallel_out_pipo_8_bit_if
  import parallel_in_parallel_out_pipo_8_bit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  enable;
  logic                  load;
  logic [DATA_WIDTH-1:0] data;

  modport master (output enable, output load, output data);
  modport slave  (input  enable, input  load, input  data);

endinterface : parallel_in_parallel_out_pipo_8_bit_if

// File: rtl/parallel_in_parallel_out_pipo_8_bit.sv
// Parallel-load storage register with an enable-gated tri-state output.
// The output follows the register combinationally; Enable_In low floats it.
module parallel_in_parallel_out_pipo_8_bit
  import parallel_in_parallel_out_pipo_8_bit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Load_Data_Signal_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output wire  [DATA_WIDTH-1:0] Parallel_Data_Out
);

  localparam logic [DATA_WIDTH-1:0] RST_VAL = DATA_WIDTH'(RESET_VALUE);

  logic [DATA_WIDTH-1:0] r_Shift_Register;

  // Full-width load only when both enabled and requested; reset wins over everything.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_Shift_Register <= RST_VAL;
    end else if (Enable_In && Load_Data_Signal_In) begin
      r_Shift_Register <= Parallel_Data_In;
    end
  end

  assign Parallel_Data_Out = Enable_In ? r_Shift_Register : {DATA_WIDTH{1'bz}};

endmodule : parallel_in_parallel_out_pipo_8_bit

// File: tb/tb_parallel_in_parallel_out_pipo_8_bit.sv
// Directed table plus hand-written sequences and a short random run against a reference model.
module tb_parallel_in_parallel_out_pipo_8_bit;

  logic       clk;
  logic       rst_n;
  wire  [7:0] pdo;
  wire        out_is_z = (pdo === 8'bzzzzzzzz);

  int checks = 0;
  int errors = 0;

  parallel_in_parallel_out_pipo_8_bit_if #(.DATA_WIDTH(8)) bus ();

  parallel_in_parallel_out_pipo_8_bit #(.DATA_WIDTH(8)) dut (
    .Clk_In              (clk),
    .Reset_In            (rst_n),
    .Enable_In           (bus.enable),
    .Load_Data_Signal_In (bus.load),
    .Parallel_Data_In    (bus.data),
    .Parallel_Data_Out   (pdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] din;
    logic       zexp;
    logic [7:0] pre;
    logic [7:0] post;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string name, input logic [7:0] exp);
    checks++;
    if (pdo !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, pdo, exp);
    end
  endtask

  task automatic chk_z(input string name);
    checks++;
    if (!out_is_z) begin
      errors++;
      $display("FAIL %s: got %h expected zz", name, pdo);
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic [7:0] din);
    bus.enable = en;
    bus.load   = ld;
    bus.data   = din;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] model;

    vecs[0] = '{1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h3C, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h5A, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h5A, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h5A, 8'h5A};
    vecs[7] = '{1'b0, 1'b1, 8'h77, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 8'h77, 1'b0, 8'h5A, 8'h5A};
    vecs[9] = '{1'b1, 1'b1, 8'hC3, 1'b0, 8'h5A, 8'hC3};

    // Reset asserted from time zero: output follows the cleared register or floats.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'hEE);
    #3;
    chk_val("reset_en1", 8'h00);
    bus.enable = 1'b0;
    #1;
    chk_z("reset_en0");
    bus.enable = 1'b1;
    tick();
    chk_val("reset_load_ignored", 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Each row: check the pre-edge output right after driving, then the post-edge output.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].ld, vecs[i].din);
      #1;
      if (vecs[i].zexp) chk_z($sformatf("vec%0d_pre", i));
      else              chk_val($sformatf("vec%0d_pre", i), vecs[i].pre);
      tick();
      if (vecs[i].zexp) chk_z($sformatf("vec%0d_post", i));
      else              chk_val($sformatf("vec%0d_post", i), vecs[i].post);
    end

    // Async reset between edges while holding C3.
    drive(1'b1, 1'b0, 8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_reset_mid", 8'h00);
    bus.enable = 1'b0;
    #1;
    chk_z("async_reset_en0");
    drive(1'b1, 1'b1, 8'h99);
    tick();
    chk_val("reset_priority", 8'h00);

    // First edge with reset released must load.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h66);
    tick();
    chk_val("first_load_after_release", 8'h66);

    // Random loads with enable held high.
    model = 8'h66;
    for (int i = 0; i < 20; i++) begin
      logic       ld;
      logic [7:0] din;
      ld  = 1'($urandom_range(1, 0));
      din = 8'($urandom);
      drive(1'b1, ld, din);
      tick();
      if (ld) model = din;
      chk_val($sformatf("rand%0d", i), model);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parallel_in_parallel_out_pipo_8_bit
